// File: rtl/byte_unstriping_nlane.sv
// N-lane byte un-striper: per-lane FIFOs feeding a round-robin output register.
// Optional saturating drop counter on ovf_cnt when UNSTRIPE_OVF_CNT_EN is defined.

module byte_unstriping_lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW:0]                 wr_q, wr_d, rd_q, rd_d;
  logic                        full, push;

  // The extra pointer bit tells full from empty when the index bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = push_vld && (!full || pop);
  assign drop  = push_vld && full && !pop;
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule

module byte_unstriping_nlane #(
  parameter int LANES = 2,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       lane_valid,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic                   out_ready,
  output logic                   valid_out,
  output logic [WIDTH-1:0]       data_out,
  output logic [LANES-1:0]       err_ovf
`ifdef UNSTRIPE_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);
  localparam int             RW      = $clog2(LANES);
  localparam logic [RW-1:0]  RR_LAST = RW'(LANES - 1);

  logic [LANES-1:0][WIDTH-1:0] lane_words, head_all;
  logic [LANES-1:0]            empty_vec, drop_vec, pop_vec;
  logic [RW-1:0]               rr_q, rr_d;
  logic                        valid_q, valid_d;
  logic [WIDTH-1:0]            data_q, data_d;
  logic [LANES-1:0]            err_q, err_d;
  logic                        out_free, pop_sel;

  assign lane_words = lane_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    byte_unstriping_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_vld  (lane_valid[i]),
      .push_data (lane_words[i]),
      .pop       (pop_vec[i]),
      .head      (head_all[i]),
      .empty     (empty_vec[i]),
      .drop      (drop_vec[i])
    );
  end

  // Strict round-robin: an empty lane at rr_q stalls output to keep stripe order.
  assign out_free = !valid_q || out_ready;
  assign pop_sel  = out_free && !empty_vec[rr_q];

  always_comb begin
    pop_vec = '0;
    valid_d = valid_q;
    data_d  = data_q;
    rr_d    = rr_q;
    err_d   = err_q | drop_vec;
    if (out_free) begin
      valid_d = pop_sel;
      if (pop_sel) begin
        pop_vec[rr_q] = 1'b1;
        data_d        = head_all[rr_q];
        rr_d          = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rr_q    <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign err_ovf   = err_q;

`ifdef UNSTRIPE_OVF_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (|drop_vec && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`endif
endmodule
